// File: rtl/aes_iter_ctrl.sv
// rtl/aes_iter_ctrl.sv - iterative AES-128 encryption controller, one round per clock
//
// Purpose:
//   Accepts a plaintext block and a cipher key over a valid/ready handshake,
//   runs the ten AES-128 rounds through a single shared round datapath with
//   on-the-fly key expansion, and presents the ciphertext over a second
//   valid/ready handshake. One block in flight at a time.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset, highest priority
//   in_valid   plaintext/key valid
//   in_ready   controller idle and able to accept a block
//   pt_in      plaintext, byte 0 = bits [0:7], column-major state order
//   key_in     cipher key, same byte order
//   out_valid  ciphertext valid (registered)
//   out_ready  consumer accepts ciphertext
//   ct_out     ciphertext (registered), held stable while stalled
//   abort      only with AES_ITER_CTRL_ABORT_EN: drops the in-flight block
//
// Build option:
//   AES_ITER_CTRL_ABORT_EN - adds the abort port and its flush logic.

module sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    // Multiplication in GF(2^8) modulo x^8+x^4+x^3+x+1 (0x11b).
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = x;
        for (int i = 0; i < 8; i++) begin
            if (z[i]) acc = acc ^ sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    logic [7:0] inv;
    logic [7:0] sq;

    // Multiplicative inverse as a^254 (= a^2 * a^4 * ... * a^128); maps 0 to 0.
    always_comb begin
        sq  = a;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
    end

    // Affine transform over GF(2).
    assign y = inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;
endmodule

module aes_iter_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] pt_in,
    input  logic [0:127] key_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] ct_out
`ifdef AES_ITER_CTRL_ABORT_EN
    ,
    input  logic         abort
`endif
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_q;
    state_t       state_d;

    logic [0:127] state_reg;
    logic [0:127] rk_reg;
    logic [0:127] ct_reg;
    logic [3:0]   rnd;
    logic         out_valid_q;

    logic         load;
    logic         step;
`ifdef AES_ITER_CTRL_ABORT_EN
    logic         flush;
`endif

    logic         last_round;
    assign last_round = (rnd == 4'd10);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Round constant for round 1..10; unused rounds return zero.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Key schedule: rk_next = KeyExpand(rk_reg, rcon[rnd])
    // ------------------------------------------------------------------
    logic [7:0]  ks_in  [4];
    logic [7:0]  ks_out [4];
    logic [31:0] ks_temp;
    logic [31:0] nw0, nw1, nw2, nw3;
    logic [0:127] rk_next;

    // RotWord(w3): byte order 13,14,15,12 of the current round key.
    always_comb begin
        ks_in[0] = rk_reg[104:111];
        ks_in[1] = rk_reg[112:119];
        ks_in[2] = rk_reg[120:127];
        ks_in[3] = rk_reg[96:103];
    end

    for (genvar g = 0; g < 4; g++) begin : g_ks_sbox
        sbox u_sbox (
            .a (ks_in[g]),
            .y (ks_out[g])
        );
    end

    assign ks_temp = {ks_out[0] ^ rcon(rnd), ks_out[1], ks_out[2], ks_out[3]};
    assign nw0     = rk_reg[0:31]   ^ ks_temp;
    assign nw1     = rk_reg[32:63]  ^ nw0;
    assign nw2     = rk_reg[64:95]  ^ nw1;
    assign nw3     = rk_reg[96:127] ^ nw2;
    assign rk_next = {nw0, nw1, nw2, nw3};

    // ------------------------------------------------------------------
    // Round datapath: SubBytes -> ShiftRows -> MixColumns (skipped in
    // round 10) -> AddRoundKey. Byte index is row + 4*column.
    // ------------------------------------------------------------------
    logic [7:0]   sb_in  [16];
    logic [7:0]   sb_out [16];
    logic [7:0]   sr     [16];
    logic [7:0]   mc     [16];
    logic [0:127] round_out;

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            sb_in[i] = state_reg[8*i +: 8];
        end
    end

    for (genvar g = 0; g < 16; g++) begin : g_sub_sbox
        sbox u_sbox (
            .a (sb_in[g]),
            .y (sb_out[g])
        );
    end

    // Row r is rotated left by r columns.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                sr[r + 4*c] = sb_out[r + 4*((c + r) % 4)];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            mc[4*c+0] = xtime(sr[4*c+0]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c+0] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c+0] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c+3] = xtime(sr[4*c+0]) ^ sr[4*c+0] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
        end
    end

    always_comb begin
        round_out = '0;
        for (int i = 0; i < 16; i++) begin
            round_out[8*i +: 8] = (last_round ? sr[i] : mc[i]) ^ rk_next[8*i +: 8];
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        step     = 1'b0;
        in_ready = 1'b0;
`ifdef AES_ITER_CTRL_ABORT_EN
        flush    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last_round) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef AES_ITER_CTRL_ABORT_EN
        // Abort outranks round progress and the output handshake.
        if (abort && (state_q != IDLE)) begin
            step    = 1'b0;
            flush   = 1'b1;
            state_d = IDLE;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= '0;
            rk_reg      <= '0;
            ct_reg      <= '0;
            rnd         <= 4'd0;
            out_valid_q <= 1'b0;
        end else begin
            // out_valid is a flop tracking entry into DONE.
            out_valid_q <= (state_d == DONE);
`ifdef AES_ITER_CTRL_ABORT_EN
            if (flush) begin
                state_reg <= '0;
                rk_reg    <= '0;
                ct_reg    <= '0;
                rnd       <= 4'd0;
            end else
`endif
            if (load) begin
                state_reg <= pt_in ^ key_in;
                rk_reg    <= key_in;
                rnd       <= 4'd1;
            end else if (step) begin
                state_reg <= round_out;
                rk_reg    <= rk_next;
                rnd       <= rnd + 4'd1;
                // A dedicated output register keeps intermediate round
                // states off ct_out.
                if (last_round) ct_reg <= round_out;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign ct_out    = ct_reg;

endmodule

// File: tb/tb_aes_iter_ctrl.sv
// tb/tb_aes_iter_ctrl.sv - self-checking bench for aes_iter_ctrl against an AES-128 reference model

module tb_aes_iter_ctrl;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [0:127] pt_in;
    logic [0:127] key_in;
    logic         out_valid;
    logic         out_ready;
    logic [0:127] ct_out;
`ifdef AES_ITER_CTRL_ABORT_EN
    logic         abort;
`endif

    int checks;
    int failures;

    logic [7:0] sb [256];

    aes_iter_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pt_in     (pt_in),
        .key_in    (key_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ct_out    (ct_out)
`ifdef AES_ITER_CTRL_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // S-box built by walking generator 3 and its inverse simultaneously.
    task automatic build_sbox();
        logic [7:0] p;
        logic [7:0] q;
        logic [7:0] x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'b0000};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    function automatic logic [0:127] aes_ref(input logic [0:127] pt, input logic [0:127] key);
        logic [7:0]   w [176];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   tmp [4];
        logic [7:0]   rc;
        logic [7:0]   a0, a1, a2, a3;
        logic [0:127] res;
        for (int i = 0; i < 16; i++) w[i] = key[8*i +: 8];
        rc = 8'h01;
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i-4+j];
            if (i % 16 == 0) begin
                a0 = tmp[0];
                tmp[0] = sb[tmp[1]] ^ rc;
                tmp[1] = sb[tmp[2]];
                tmp[2] = sb[tmp[3]];
                tmp[3] = sb[a0];
                rc = xt(rc);
            end
            for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] = pt[8*i +: 8] ^ w[i];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
            for (int row = 0; row < 4; row++)
                for (int c = 0; c < 4; c++)
                    t[row + 4*c] = s[row + 4*((c + row) % 4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = t[i] ^ w[16*r + i];
        end
        for (int i = 0; i < 16; i++) res[8*i +: 8] = s[i];
        return res;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one block for a single edge; caller ensures in_ready.
    task automatic send(input logic [0:127] pt, input logic [0:127] key);
        pt_in    = pt;
        key_in   = key;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Edges from now until out_valid is seen, or -1 after the budget.
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        if (!out_valid) n = -1;
    endtask

    logic [0:127] vec_b_pt, vec_b_key, vec_b_ct;
    logic [0:127] vec_c_pt, vec_c_key, vec_c_ct;

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (ct_out !== 128'h0) begin failures++; $display("FAIL reset_ct_out got=%h exp=0", ct_out); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fips_b();
        int n;
        out_ready = 1'b1;
        send(vec_b_pt, vec_b_key);
        wait_valid(n);
        checks++;
        if (n !== 10) begin failures++; $display("FAIL fips_b_latency got=%0d exp=10", n); end
        checks++;
        if (ct_out !== vec_b_ct) begin failures++; $display("FAIL fips_b_ct got=%h exp=%h", ct_out, vec_b_ct); end
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++; $display("FAIL fips_b_return in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_fips_c1();
        int n;
        out_ready = 1'b1;
        send(vec_c_pt, vec_c_key);
        wait_valid(n);
        checks++;
        if (n !== 10) begin failures++; $display("FAIL fips_c1_latency got=%0d exp=10", n); end
        checks++;
        if (ct_out !== vec_c_ct) begin failures++; $display("FAIL fips_c1_ct got=%h exp=%h", ct_out, vec_c_ct); end
        tick();
    endtask

    task automatic test_random();
        int n;
        int stall;
        logic [0:127] pt, key, exp;
        for (int k = 0; k < 8; k++) begin
            pt  = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            exp = aes_ref(pt, key);
            out_ready = 1'b0;
            send(pt, key);
            wait_valid(n);
            checks++;
            if (n !== 10) begin failures++; $display("FAIL rand_latency[%0d] got=%0d exp=10", k, n); end
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) tick();
            checks++;
            if (ct_out !== exp || out_valid !== 1'b1) begin
                failures++; $display("FAIL rand_ct[%0d] got=%h v=%b exp=%h", k, ct_out, out_valid, exp);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            checks++;
            if (in_ready !== 1'b1) begin failures++; $display("FAIL rand_ready[%0d] got=%b exp=1", k, in_ready); end
        end
    endtask

    task automatic test_backpressure();
        int n;
        logic [0:127] pt, key, exp;
        pt  = {$urandom, $urandom, $urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
        exp = aes_ref(pt, key);
        out_ready = 1'b0;
        send(pt, key);
        wait_valid(n);
        checks++;
        if (n !== 10) begin failures++; $display("FAIL bp_latency got=%0d exp=10", n); end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (out_valid !== 1'b1 || ct_out !== exp || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold[%0d] v=%b rdy=%b ct=%h exp v=1 rdy=0 ct=%h", c, out_valid, in_ready, ct_out, exp);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++; $display("FAIL bp_release in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_busy_input();
        int n;
        logic [0:127] pa, ka, pb, kb, ea, eb;
        pa = {$urandom, $urandom, $urandom, $urandom};
        ka = {$urandom, $urandom, $urandom, $urandom};
        pb = {$urandom, $urandom, $urandom, $urandom};
        kb = {$urandom, $urandom, $urandom, $urandom};
        ea = aes_ref(pa, ka);
        eb = aes_ref(pb, kb);
        out_ready = 1'b1;
        send(pa, ka);
        // Requester raises and holds a second block while the first runs.
        pt_in    = pb;
        key_in   = kb;
        in_valid = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL busy_in_ready got=%b exp=0", in_ready); end
        wait_valid(n);
        checks++;
        if (n !== 9) begin failures++; $display("FAIL busy_latency got=%0d exp=9", n); end
        checks++;
        if (ct_out !== ea) begin failures++; $display("FAIL busy_first_ct got=%h exp=%h", ct_out, ea); end
        tick();
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL busy_idle got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        wait_valid(n);
        checks++;
        if (n !== 10) begin failures++; $display("FAIL busy_second_latency got=%0d exp=10", n); end
        checks++;
        if (ct_out !== eb) begin failures++; $display("FAIL busy_second_ct got=%h exp=%h", ct_out, eb); end
        tick();
    endtask

    task automatic test_reset_mid();
        int n;
        int seen;
        out_ready = 1'b1;
        send(vec_b_pt, vec_b_key);
        for (int c = 0; c < 4; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || ct_out !== 128'h0) begin
            failures++;
            $display("FAIL rstmid_state rdy=%b v=%b ct=%h exp 1/0/0", in_ready, out_valid, ct_out);
        end
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (out_valid) seen++;
            tick();
        end
        checks++;
        if (seen !== 0) begin failures++; $display("FAIL rstmid_no_valid got=%0d exp=0", seen); end
        send(vec_b_pt, vec_b_key);
        wait_valid(n);
        checks++;
        if (ct_out !== vec_b_ct || n !== 10) begin
            failures++; $display("FAIL rstmid_next_ct got=%h n=%0d exp=%h n=10", ct_out, n, vec_b_ct);
        end
        tick();
    endtask

`ifdef AES_ITER_CTRL_ABORT_EN
    task automatic test_abort();
        int n;
        int seen;
        out_ready = 1'b1;
        send(vec_c_pt, vec_c_key);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++; $display("FAIL abort_idle rdy=%b v=%b exp 1/0", in_ready, out_valid);
        end
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (out_valid) seen++;
            tick();
        end
        checks++;
        if (seen !== 0) begin failures++; $display("FAIL abort_no_valid got=%0d exp=0", seen); end
        send(vec_c_pt, vec_c_key);
        wait_valid(n);
        checks++;
        if (ct_out !== vec_c_ct || n !== 10) begin
            failures++; $display("FAIL abort_next_ct got=%h n=%0d exp=%h n=10", ct_out, n, vec_c_ct);
        end
        tick();
    endtask
`endif

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        pt_in     = '0;
        key_in    = '0;
`ifdef AES_ITER_CTRL_ABORT_EN
        abort     = 1'b0;
`endif
        vec_b_pt  = 128'h3243f6a8885a308d313198a2e0370734;
        vec_b_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        vec_b_ct  = 128'h3925841d02dc09fbdc118597196a0b32;
        vec_c_pt  = 128'h00112233445566778899aabbccddeeff;
        vec_c_key = 128'h000102030405060708090a0b0c0d0e0f;
        vec_c_ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        build_sbox();

        test_reset();
        test_fips_b();
        test_fips_c1();
        test_random();
        test_backpressure();
        test_busy_input();
        test_reset_mid();
`ifdef AES_ITER_CTRL_ABORT_EN
        test_abort();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
